// File: rtl/alu_ctrl_issue_if.sv
// ID/EX-to-ALU control handshake bundle.
// The master drives the instruction side; the slave (alu_ctrl_issue) drives the ALU side.
interface alu_ctrl_issue_if;
  logic       flush_i;
  logic       valid_i;
  logic [1:0] ALUOp_i;
  logic [5:0] funct_i;
  logic       ready_o;
  logic [2:0] ALUCtrl_o;
  logic       valid_o;
  logic       stall_o;
  logic       illegal_o;

  modport master (
    output flush_i, valid_i, ALUOp_i, funct_i,
    input  ready_o, ALUCtrl_o, valid_o, stall_o, illegal_o
  );

  modport slave (
    input  flush_i, valid_i, ALUOp_i, funct_i,
    output ready_o, ALUCtrl_o, valid_o, stall_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ALU control decode/issue stage with optional multi-cycle MUL hold.
// Define ALU_MUL_MULTICYCLE_EN to build the MUL_HOLD sequence and the front-end stall.
module alu_ctrl_issue #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_ctrl_issue_if.slave bus
);

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_AND = 3'b010;
  localparam logic [2:0] C_OR  = 3'b011;
  localparam logic [2:0] C_MUL = 3'b101;

  if (MUL_CYCLES < 2 || MUL_CYCLES > 15 || (2 ** CNT_W) <= MUL_CYCLES) begin : g_param_check
    $error("alu_ctrl_issue: MUL_CYCLES must be 2..15 and fit in CNT_W bits");
  end

  logic [2:0] w_dec_ctrl;
  logic       w_dec_illegal;
  logic       w_ready;
  logic       w_accept;
  logic [2:0] r_alu_ctrl;
  logic       r_valid;
  logic       r_illegal;

  always_comb begin
    w_dec_ctrl    = C_ADD;
    w_dec_illegal = 1'b0;
    unique case (bus.ALUOp_i)
      2'b00: w_dec_ctrl = C_ADD;
      2'b01: w_dec_ctrl = C_SUB;
      2'b11: w_dec_ctrl = C_OR;
      default: begin
        case (bus.funct_i)
          6'b100000: w_dec_ctrl = C_ADD;
          6'b100010: w_dec_ctrl = C_SUB;
          6'b100100: w_dec_ctrl = C_AND;
          6'b100101: w_dec_ctrl = C_OR;
          6'b011000: w_dec_ctrl = C_MUL;
          default: begin
            w_dec_ctrl    = C_ADD;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign w_accept = bus.valid_i & w_ready & ~bus.flush_i;

`ifdef ALU_MUL_MULTICYCLE_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_MUL_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;
  logic             w_dec_mul;

  assign w_dec_mul = (w_dec_ctrl == C_MUL);
  assign w_ready   = ~r_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_alu_ctrl <= C_ADD;
      r_valid    <= 1'b0;
      r_stall    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (bus.flush_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_stall   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == ST_MUL_HOLD && r_cnt != '0) begin
      // Counting down the hold; the 1->0 step opens the final, result-valid cycle.
      r_cnt     <= r_cnt - 1'b1;
      r_valid   <= (r_cnt == CNT_W'(1));
      r_stall   <= (r_cnt != CNT_W'(1));
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_ctrl <= w_dec_ctrl;
      if (w_dec_mul) begin
        r_state   <= ST_MUL_HOLD;
        r_cnt     <= CNT_W'(MUL_CYCLES - 1);
        r_valid   <= 1'b0;
        r_stall   <= 1'b1;
        r_illegal <= 1'b0;
      end else begin
        r_state   <= ST_ISSUE;
        r_cnt     <= '0;
        r_valid   <= 1'b1;
        r_stall   <= 1'b0;
        r_illegal <= w_dec_illegal;
      end
    end else begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_stall   <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign bus.stall_o = r_stall;
`else
  assign w_ready = 1'b1;

  // Single-cycle build: every op, MUL included, issues for exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_alu_ctrl <= C_ADD;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_alu_ctrl <= w_dec_ctrl;
      r_valid    <= 1'b1;
      r_illegal  <= w_dec_illegal;
    end else begin
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
    end
  end

  assign bus.stall_o = 1'b0;
`endif

  assign bus.ready_o   = w_ready;
  assign bus.ALUCtrl_o = r_alu_ctrl;
  assign bus.valid_o   = r_valid;
  assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Randomized self-checking bench for alu_ctrl_issue against a cycle-count reference model.
// Honours ALU_MUL_MULTICYCLE_EN in the same way as the design.
module tb_alu_ctrl_issue;
  localparam int MUL_CYCLES = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_ctrl_issue_if bus ();

  alu_ctrl_issue #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

`ifdef ALU_MUL_MULTICYCLE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  // Reference model: remaining stall cycles plus the visible outputs.
  int       m_hold;
  bit [2:0] m_ctrl;
  bit       m_valid;
  bit       m_illegal;

  function automatic bit [4:0] decode(input bit [1:0] op, input bit [5:0] fn);
    // returns {illegal, is_mul, ctrl}
    if (op == 2'b00) return 5'b00_000;
    if (op == 2'b01) return 5'b00_001;
    if (op == 2'b11) return 5'b00_011;
    case (fn)
      6'b100000: return 5'b00_000;
      6'b100010: return 5'b00_001;
      6'b100100: return 5'b00_010;
      6'b100101: return 5'b00_011;
      6'b011000: return 5'b01_101;
      default:   return 5'b10_000;
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    bit [4:0] d;
    if (!rst_i) begin
      m_hold = 0; m_ctrl = 3'b000; m_valid = 1'b0; m_illegal = 1'b0;
    end else if (bus.flush_i) begin
      m_hold = 0; m_valid = 1'b0; m_illegal = 1'b0;
    end else if (m_hold > 0) begin
      m_hold    = m_hold - 1;
      m_valid   = (m_hold == 0);
      m_illegal = 1'b0;
    end else if (bus.valid_i) begin
      d      = decode(bus.ALUOp_i, bus.funct_i);
      m_ctrl = d[2:0];
      if (d[3] && EN) begin
        m_hold = MUL_CYCLES - 1; m_valid = 1'b0; m_illegal = 1'b0;
      end else begin
        m_valid = 1'b1; m_illegal = d[4];
      end
    end else begin
      m_valid = 1'b0; m_illegal = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    check("model_ctrl",    int'(bus.ALUCtrl_o), int'(m_ctrl));
    check("model_valid",   int'(bus.valid_o),   int'(m_valid));
    check("model_illegal", int'(bus.illegal_o), int'(m_illegal));
    check("model_stall",   int'(bus.stall_o),   int'(m_hold > 0));
    check("model_ready",   int'(bus.ready_o),   int'(m_hold == 0));
  end

  task automatic cyc(input bit v, input bit [1:0] op, input bit [5:0] fn, input bit fl);
    bus.valid_i = v; bus.ALUOp_i = op; bus.funct_i = fn; bus.flush_i = fl;
    @(negedge clk_i);
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    $display("txn t=%0t v=%0b op=%0b fn=%b fl=%0b -> ctrl=%b valid=%0b ill=%0b stall=%0b",
             $time, v, op, fn, fl, bus.ALUCtrl_o, bus.valid_o, bus.illegal_o, bus.stall_o);
  endtask

  initial begin
    bit [5:0] fn_tab [8];
    bit [2:0] sweep_exp [4];
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000, 6'b011000, 6'b000111, 6'b111111};
    sweep_exp = '{3'b000, 3'b001, 3'b010, 3'b011};
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ALUOp_i = 2'b00; bus.funct_i = 6'd0;
    repeat (2) @(negedge clk_i);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_stall", int'(bus.stall_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Async reset in the middle of a MUL
    cyc(1'b1, 2'b10, 6'b011000, 1'b0);
    cyc(1'b0, 2'b00, 6'd0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    check("midmul_rst_ctrl",  int'(bus.ALUCtrl_o), 0);
    check("midmul_rst_valid", int'(bus.valid_o),   0);
    check("midmul_rst_stall", int'(bus.stall_o),   0);
    check("midmul_rst_ready", int'(bus.ready_o),   1);
    @(negedge clk_i);
    rst_i = 1'b1;
    cyc(1'b1, 2'b00, 6'd0, 1'b0);
    check("post_rst_ctrl",  int'(bus.ALUCtrl_o), 0);
    check("post_rst_valid", int'(bus.valid_o),   1);

    // Decode sweep, back to back
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b10, fn_tab[i], 1'b0);
      check("sweep_ctrl",    int'(bus.ALUCtrl_o), int'(sweep_exp[i]));
      check("sweep_valid",   int'(bus.valid_o),   1);
      check("sweep_illegal", int'(bus.illegal_o), 0);
    end
    cyc(1'b1, 2'b10, 6'b000111, 1'b0);
    check("illegal_ctrl",  int'(bus.ALUCtrl_o), 0);
    check("illegal_flag",  int'(bus.illegal_o), 1);
    check("illegal_valid", int'(bus.valid_o),   1);
    cyc(1'b0, 2'b00, 6'd0, 1'b0);
    check("illegal_drop",  int'(bus.illegal_o), 0);

    // MUL sequence, ADD offered in the final cycle
    cyc(1'b1, 2'b10, 6'b011000, 1'b0);
    check("mul_c1_ctrl",  int'(bus.ALUCtrl_o), 5);
    check("mul_c1_valid", int'(bus.valid_o),   EN ? 0 : 1);
    check("mul_c1_stall", int'(bus.stall_o),   EN ? 1 : 0);
    if (EN) begin
      cyc(1'b1, 2'b01, 6'd0, 1'b0);
      cyc(1'b0, 2'b00, 6'd0, 1'b0);
      check("mul_c3_stall", int'(bus.stall_o), 1);
      check("mul_c3_ctrl",  int'(bus.ALUCtrl_o), 5);
      cyc(1'b0, 2'b00, 6'd0, 1'b0);
      check("mul_c4_valid", int'(bus.valid_o), 1);
      check("mul_c4_stall", int'(bus.stall_o), 0);
      cyc(1'b1, 2'b00, 6'd0, 1'b0);
      check("mul_c5_ctrl",  int'(bus.ALUCtrl_o), 0);
      check("mul_c5_valid", int'(bus.valid_o),   1);

      // Flush in cycle 2; the SUB offered while stalled must not issue
      cyc(1'b1, 2'b10, 6'b011000, 1'b0);
      cyc(1'b1, 2'b01, 6'd0, 1'b0);
      cyc(1'b1, 2'b01, 6'd0, 1'b1);
      check("flush_stall", int'(bus.stall_o),   0);
      check("flush_valid", int'(bus.valid_o),   0);
      check("flush_ctrl",  int'(bus.ALUCtrl_o), 5);
      cyc(1'b0, 2'b00, 6'd0, 1'b0);
      check("flush_no_sub", int'(bus.valid_o), 0);
    end else begin
      cyc(1'b0, 2'b00, 6'd0, 1'b0);
      check("nomul_stall", int'(bus.stall_o), 0);
      check("nomul_valid", int'(bus.valid_o), 0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, fl;
      bit [1:0] op;
      bit [5:0] fn;
      v  = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 5);
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 7)];
      cyc(v, op, fn, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
